// File: rtl/mem_ctrl_arb.sv
// mem_ctrl_arb: byte-serial controller between an 8-bit single-port RAM/IO bus and two requesters (ifetch line filler, LSB).
// Latency: grant edge E0; reads ack in cycle N+2, writes ack in cycle N+1 plus one cycle per IO stall.
// Backpressure: rdy=0 freezes every register and masks mem_wr; io_buffer_full stalls IO-region stores byte by byte.
//
// Parameters:
//   ADDR_W     address width
//   BLK_BYTES  ifetch line size in bytes (power of two, 4..128)
//   IO_SEL     addr[17:16] value that marks the IO region
// Ports:
//   clk, rst_n (async active-low), rdy (global enable), rollback (pipeline flush)
//   mem_din / mem_a / mem_wr / mem_dout   RAM/IO byte bus (read data one cycle after address)
//   io_buffer_full                        IO sink cannot accept a byte
//   if_req / if_addr / if_ack / if_line   ifetch line request and returned line
//   ls_req / ls_we / ls_addr / ls_len / ls_signed / ls_wdata / ls_ack / ls_rdata   load/store request
// Build option:
//   MEMCTRL_RR_ARB_EN  defined -> round-robin arbitration between ifetch and LSB;
//                      undefined -> fixed priority, ifetch wins ties.

module mem_ctrl_arb #(
  parameter int         ADDR_W    = 32,
  parameter int         BLK_BYTES = 64,
  parameter logic [1:0] IO_SEL    = 2'b11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rdy,
  input  logic                   rollback,
  input  logic [7:0]             mem_din,
  output logic [ADDR_W-1:0]      mem_a,
  output logic                   mem_wr,
  output logic [7:0]             mem_dout,
  input  logic                   io_buffer_full,
  input  logic                   if_req,
  input  logic [ADDR_W-1:0]      if_addr,
  output logic                   if_ack,
  output logic [BLK_BYTES*8-1:0] if_line,
  input  logic                   ls_req,
  input  logic                   ls_we,
  input  logic [ADDR_W-1:0]      ls_addr,
  input  logic [2:0]             ls_len,
  input  logic                   ls_signed,
  input  logic [31:0]            ls_wdata,
  output logic                   ls_ack,
  output logic [31:0]            ls_rdata
);

  localparam int CNT_W = $clog2(BLK_BYTES) + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  localparam logic [CNT_W-1:0] N0    = '0;
  localparam logic [CNT_W-1:0] N1    = CNT_W'(1);
  localparam logic [CNT_W-1:0] N2    = CNT_W'(2);
  localparam logic [CNT_W-1:0] N4    = CNT_W'(4);
  localparam logic [CNT_W-1:0] BLK_N = CNT_W'(BLK_BYTES);

  // Transaction state latched at grant
  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;        // bytes issued so far (reads run one past N to drain the RAM pipeline)
  logic [CNT_W-1:0]  num;        // total bytes in this transaction
  logic [ADDR_W-1:0] base;
  logic              owner_if;   // 1: ifetch owns the transaction, 0: LSB
  logic              sgn;
  logic              io_region;
  logic [31:0]       wdata;
  logic              mem_wr_q;

`ifdef MEMCTRL_RR_ARB_EN
  logic              rr_ptr;     // 0: ifetch wins the next tie, 1: LSB wins
`endif

  // Byte bus write strobe is masked while frozen so the RAM never sees a stale strobe
  assign mem_wr = mem_wr_q & rdy;

  // Arbitration: one dead cycle after any ack so requesters can drop req
  logic can_grant;
  logic grant_if;
  logic grant_ls;

  assign can_grant = (state == ST_IDLE) && !rollback && !if_ack && !ls_ack;

`ifdef MEMCTRL_RR_ARB_EN
  assign grant_if = can_grant && if_req && (!ls_req || !rr_ptr);
`else
  assign grant_if = can_grant && if_req;
`endif
  assign grant_ls = can_grant && ls_req && !grant_if;

  // Length decode: anything other than 1 or 2 is a word access
  logic [CNT_W-1:0] ls_num;
  always_comb begin
    case (ls_len)
      3'd1:    ls_num = N1;
      3'd2:    ls_num = N2;
      default: ls_num = N4;
    endcase
  end

  logic ls_io;
  assign ls_io = (ls_addr[17:16] == IO_SEL);

  // Address of the byte being issued this edge
  logic [ADDR_W-1:0] cnt_addr;
  assign cnt_addr = base + {{(ADDR_W-CNT_W){1'b0}}, cnt};

  // Store byte selected by the issue counter (stores are at most 4 bytes)
  logic [7:0] wr_byte;
  assign wr_byte = wdata[{cnt[1:0], 3'b000} +: 8];

  // Read data for issue index i arrives two edges after issue, so at an
  // edge with counter value cnt the byte on mem_din belongs to slot cnt-2.
  logic [CNT_W-1:0] slot;
  logic             capture;
  logic             last_cap;
  assign slot     = cnt - N2;
  assign capture  = (cnt >= N2);
  assign last_cap = (cnt == num + N1);

  // Next load result: insert the arriving byte, sign-extend on the final byte
  logic [31:0] ld_next;
  always_comb begin
    ld_next = ls_rdata;
    ld_next[{slot[1:0], 3'b000} +: 8] = mem_din;
    if (last_cap && sgn) begin
      if (num == N1) begin
        ld_next[31:8] = {24{mem_din[7]}};
      end else if (num == N2) begin
        ld_next[31:16] = {16{mem_din[7]}};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= N0;
      num       <= N0;
      base      <= '0;
      owner_if  <= 1'b0;
      sgn       <= 1'b0;
      io_region <= 1'b0;
      wdata     <= '0;
      mem_a     <= '0;
      mem_wr_q  <= 1'b0;
      mem_dout  <= 8'h00;
      if_ack    <= 1'b0;
      ls_ack    <= 1'b0;
      if_line   <= '0;
      ls_rdata  <= '0;
`ifdef MEMCTRL_RR_ARB_EN
      rr_ptr    <= 1'b0;
`endif
    end else if (rdy) begin
      if_ack <= 1'b0;
      ls_ack <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (grant_if) begin
            state    <= ST_READ;
            owner_if <= 1'b1;
            base     <= if_addr;
            num      <= BLK_N;
            mem_a    <= if_addr;
            mem_wr_q <= 1'b0;
            cnt      <= N1;
`ifdef MEMCTRL_RR_ARB_EN
            if (ls_req) rr_ptr <= 1'b1;
`endif
          end else if (grant_ls) begin
            owner_if  <= 1'b0;
            base      <= ls_addr;
            num       <= ls_num;
            sgn       <= ls_signed;
            wdata     <= ls_wdata;
            io_region <= ls_io;
            mem_a     <= ls_addr;
`ifdef MEMCTRL_RR_ARB_EN
            if (if_req) rr_ptr <= 1'b0;
`endif
            if (ls_we) begin
              state <= ST_WRITE;
              // The first byte goes out on the grant edge unless the IO sink is full
              if (ls_io && io_buffer_full) begin
                cnt      <= N0;
                mem_wr_q <= 1'b0;
              end else begin
                cnt      <= N1;
                mem_wr_q <= 1'b1;
                mem_dout <= ls_wdata[7:0];
              end
            end else begin
              state    <= ST_READ;
              ls_rdata <= '0;
              mem_wr_q <= 1'b0;
              cnt      <= N1;
            end
          end
        end

        ST_READ: begin
          if (rollback) begin
            // Abort immediately; the partial result is left as is
            state <= ST_IDLE;
            mem_a <= '0;
          end else begin
            if (cnt < num) begin
              mem_a <= cnt_addr;
            end else begin
              mem_a <= '0;
            end
            if (capture) begin
              if (owner_if) begin
                if_line[{slot, 3'b000} +: 8] <= mem_din;
              end else begin
                ls_rdata <= ld_next;
              end
            end
            if (last_cap) begin
              state <= ST_IDLE;
              if (owner_if) begin
                if_ack <= 1'b1;
              end else begin
                ls_ack <= 1'b1;
              end
            end else begin
              cnt <= cnt + N1;
            end
          end
        end

        ST_WRITE: begin
          // Stores are already committed to the pipeline, so rollback is ignored here
          if (cnt == num) begin
            state    <= ST_IDLE;
            mem_wr_q <= 1'b0;
            mem_a    <= '0;
            ls_ack   <= 1'b1;
          end else if (io_region && io_buffer_full) begin
            mem_wr_q <= 1'b0;
          end else begin
            mem_a    <= cnt_addr;
            mem_dout <= wr_byte;
            mem_wr_q <= 1'b1;
            cnt      <= cnt + N1;
          end
        end

        default: begin
          state    <= ST_IDLE;
          mem_wr_q <= 1'b0;
          mem_a    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl_arb.sv
// tb_mem_ctrl_arb: directed bench for mem_ctrl_arb with a byte RAM model.
// Latency: checks ack cycles relative to the grant edge.
// Backpressure: exercises rdy freeze, IO stall and rollback.

module tb_mem_ctrl_arb;

  localparam int ADDR_W = 32;
  localparam int BLK    = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rdy;
  logic              rollback;
  logic [7:0]        mem_din;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic [7:0]        mem_dout;
  logic              io_buffer_full;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [BLK*8-1:0]  if_line;
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [2:0]        ls_len;
  logic              ls_signed;
  logic [31:0]       ls_wdata;
  logic              ls_ack;
  logic [31:0]       ls_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_ctrl_arb #(.ADDR_W(ADDR_W), .BLK_BYTES(BLK), .IO_SEL(2'b11)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback),
    .mem_din(mem_din), .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_line(if_line),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_len(ls_len),
    .ls_signed(ls_signed), .ls_wdata(ls_wdata), .ls_ack(ls_ack), .ls_rdata(ls_rdata)
  );

  // RAM model: default contents RAM[a] = a[7:0] with a few overrides; written bytes kept sparsely.
  logic [7:0] ram [int];

  function automatic logic [7:0] init_val(input logic [31:0] a);
    case (a)
      32'h200: init_val = 8'h80;
      32'h210: init_val = 8'h34;
      32'h211: init_val = 8'h92;
      default: init_val = a[7:0];
    endcase
  endfunction

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (ram.exists(int'(a))) rd = ram[int'(a)];
    else rd = init_val(a);
  endfunction

  always @(posedge clk) begin
    if (rdy) begin
      mem_din <= rd(mem_a);
      if (mem_wr && mem_a[17:16] != 2'b11) ram[int'(mem_a)] = mem_dout;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0;
    ls_len = 3'd1; ls_signed = 1'b0; ls_wdata = '0;
    repeat (2) @(negedge clk);
    checks++; if (mem_a !== 32'h0) begin failures++; $display("FAIL reset_mem_a got=%h exp=0", mem_a); end
    checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL reset_mem_wr got=%b exp=0", mem_wr); end
    checks++; if (mem_dout !== 8'h0) begin failures++; $display("FAIL reset_mem_dout got=%h exp=0", mem_dout); end
    checks++; if (if_ack !== 1'b0) begin failures++; $display("FAIL reset_if_ack got=%b exp=0", if_ack); end
    checks++; if (ls_ack !== 1'b0) begin failures++; $display("FAIL reset_ls_ack got=%b exp=0", ls_ack); end
    checks++; if (if_line !== '0) begin failures++; $display("FAIL reset_if_line got nonzero exp=0"); end
    checks++; if (ls_rdata !== 32'h0) begin failures++; $display("FAIL reset_ls_rdata got=%h exp=0", ls_rdata); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_ifetch();
    logic [BLK*8-1:0] exp_line;
    if_addr = 32'h100; if_req = 1'b1;
    step();
    for (int c = 1; c <= BLK + 2; c++) begin
      if (c <= BLK) begin
        checks++;
        if (mem_a !== 32'h100 + c - 1) begin
          failures++; $display("FAIL ifetch_addr cycle=%0d got=%h exp=%h", c, mem_a, 32'h100 + c - 1);
        end
      end
      checks++;
      if (if_ack !== (c == BLK + 2)) begin
        failures++; $display("FAIL ifetch_ack cycle=%0d got=%b exp=%b", c, if_ack, (c == BLK + 2));
      end
      if (c < BLK + 2) step();
    end
    if_req = 1'b0;
    for (int k = 0; k < BLK; k++) exp_line[8*k +: 8] = 8'(k);
    checks++;
    if (if_line !== exp_line) begin failures++; $display("FAIL ifetch_line got=%h exp=%h", if_line, exp_line); end
    step();
  endtask

  task automatic test_load(input string name, input logic [31:0] addr, input logic [2:0] len,
                           input logic sgn, input logic [31:0] exp, input int lat);
    ls_addr = addr; ls_len = len; ls_signed = sgn; ls_we = 1'b0; ls_req = 1'b1;
    step();
    for (int c = 1; c <= lat; c++) begin
      checks++;
      if (ls_ack !== (c == lat)) begin
        failures++; $display("FAIL %s_ack cycle=%0d got=%b exp=%b", name, c, ls_ack, (c == lat));
      end
      if (c < lat) step();
    end
    checks++;
    if (ls_rdata !== exp) begin failures++; $display("FAIL %s_data got=%h exp=%h", name, ls_rdata, exp); end
    ls_req = 1'b0;
    step();
  endtask

  task automatic test_io_store();
    logic [31:0] w;
    w = 32'hDEADBEEF;
    ls_addr = 32'h30000; ls_len = 3'd4; ls_we = 1'b1; ls_wdata = w; ls_req = 1'b1;
    io_buffer_full = 1'b1;
    step();
    for (int c = 1; c <= 9; c++) begin
      checks++;
      if (mem_wr !== (c >= 4 && c <= 7)) begin
        failures++; $display("FAIL io_wr cycle=%0d got=%b exp=%b", c, mem_wr, (c >= 4 && c <= 7));
      end
      if (c >= 4 && c <= 7) begin
        checks++;
        if (mem_a !== 32'h30000 + c - 4 || mem_dout !== w[8*(c-4) +: 8]) begin
          failures++; $display("FAIL io_byte cycle=%0d got=%h/%h exp=%h/%h", c, mem_a, mem_dout,
                               32'h30000 + c - 4, w[8*(c-4) +: 8]);
        end
      end
      checks++;
      if (ls_ack !== (c == 8)) begin failures++; $display("FAIL io_ack cycle=%0d got=%b exp=%b", c, ls_ack, (c == 8)); end
      if (c == 3) io_buffer_full = 1'b0;
      if (c == 8) ls_req = 1'b0;
      step();
    end
  endtask

  task automatic test_store_rollback();
    ls_addr = 32'h300; ls_len = 3'd2; ls_we = 1'b1; ls_wdata = 32'h0000A55A; ls_req = 1'b1;
    step();
    rollback = 1'b1;
    step();
    rollback = 1'b0;
    step();
    checks++;
    if (ls_ack !== 1'b1) begin failures++; $display("FAIL st_rb_ack got=%b exp=1", ls_ack); end
    ls_req = 1'b0;
    step();
    checks++;
    if (rd(32'h300) !== 8'h5A || rd(32'h301) !== 8'hA5) begin
      failures++; $display("FAIL st_rb_ram got=%h%h exp=A55A", rd(32'h301), rd(32'h300));
    end
  endtask

  task automatic test_read_rollback();
    int acks;
    acks = 0;
    if_addr = 32'h400; if_req = 1'b1;
    step();
    for (int c = 1; c < 11; c++) step();
    checks++;
    if (mem_a !== 32'h40A) begin failures++; $display("FAIL rd_rb_addr got=%h exp=40a", mem_a); end
    rollback = 1'b1; if_req = 1'b0;
    step();
    rollback = 1'b0;
    checks++;
    if (mem_a !== 32'h0) begin failures++; $display("FAIL rd_rb_idle got=%h exp=0", mem_a); end
    for (int c = 0; c < 70; c++) begin
      if (if_ack) acks++;
      step();
    end
    checks++;
    if (acks !== 0) begin failures++; $display("FAIL rd_rb_noack got=%0d exp=0", acks); end
  endtask

  task automatic test_rdy_load();
    int frozen_bad;
    frozen_bad = 0;
    ls_addr = 32'h220; ls_len = 3'd4; ls_signed = 1'b0; ls_we = 1'b0; ls_req = 1'b1;
    step();
    for (int c = 1; c <= 11; c++) begin
      if (c >= 3 && c <= 7 && (mem_a !== 32'h221 || mem_wr !== 1'b0)) frozen_bad++;
      checks++;
      if (ls_ack !== (c == 11)) begin failures++; $display("FAIL rdy_ld_ack cycle=%0d got=%b exp=%b", c, ls_ack, (c == 11)); end
      if (c == 2) rdy = 1'b0;
      if (c == 7) rdy = 1'b1;
      if (c < 11) step();
    end
    checks++;
    if (frozen_bad !== 0) begin failures++; $display("FAIL rdy_ld_frozen got=%0d bad cycles exp=0", frozen_bad); end
    checks++;
    if (ls_rdata !== 32'h23222120) begin failures++; $display("FAIL rdy_ld_data got=%h exp=23222120", ls_rdata); end
    ls_req = 1'b0;
    step();
  endtask

  task automatic test_rdy_store();
    ls_addr = 32'h310; ls_len = 3'd2; ls_we = 1'b1; ls_wdata = 32'h0000C3B4; ls_req = 1'b1;
    step();
    for (int c = 1; c <= 5; c++) begin
      if (c == 1 || c == 4) begin
        checks++;
        if (mem_wr !== 1'b1 || mem_a !== (c == 1 ? 32'h310 : 32'h311)) begin
          failures++; $display("FAIL rdy_st_issue cycle=%0d got=%b/%h", c, mem_wr, mem_a);
        end
      end
      if (c == 2 || c == 3) begin
        checks++;
        if (mem_wr !== 1'b0) begin failures++; $display("FAIL rdy_st_mask cycle=%0d got=%b exp=0", c, mem_wr); end
      end
      checks++;
      if (ls_ack !== (c == 5)) begin failures++; $display("FAIL rdy_st_ack cycle=%0d got=%b exp=%b", c, ls_ack, (c == 5)); end
      if (c == 1) rdy = 1'b0;
      if (c == 3) rdy = 1'b1;
      if (c < 5) step();
    end
    ls_req = 1'b0;
    step();
    checks++;
    if (rd(32'h310) !== 8'hB4 || rd(32'h311) !== 8'hC3) begin
      failures++; $display("FAIL rdy_st_ram got=%h%h exp=C3B4", rd(32'h311), rd(32'h310));
    end
  endtask

  task automatic test_arbitration();
    int got [3];
    int n;
    int ifc;
    int both;
    int exp [3];
`ifdef MEMCTRL_RR_ARB_EN
    exp = '{0, 1, 0};
`else
    exp = '{0, 0, 1};
`endif
    n = 0; ifc = 0; both = 0;
    got = '{9, 9, 9};
    if_addr = 32'h100; ls_addr = 32'h200; ls_len = 3'd1; ls_signed = 1'b0; ls_we = 1'b0;
    if_req = 1'b1; ls_req = 1'b1;
    for (int c = 0; c < 500 && n < 3; c++) begin
      step();
      if (if_ack && ls_ack) both++;
      if (if_ack && n < 3) begin
        got[n] = 0; n++; ifc++;
        if (ifc == 2) if_req = 1'b0;
      end
      if (ls_ack && n < 3) begin
        got[n] = 1; n++; ls_req = 1'b0;
        checks++;
        if (ls_rdata !== 32'h80) begin failures++; $display("FAIL arb_ls_data got=%h exp=80", ls_rdata); end
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
    checks++;
    if (n !== 3) begin failures++; $display("FAIL arb_timeout acks=%0d exp=3", n); end
    checks++;
    if (both !== 0) begin failures++; $display("FAIL arb_both_ack got=%0d exp=0", both); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin failures++; $display("FAIL arb_order idx=%0d got=%0d exp=%0d", i, got[i], exp[i]); end
    end
    step();
  endtask

  task automatic test_async_reset();
    int bad;
    bad = 0;
    ls_addr = 32'h320; ls_len = 3'd4; ls_we = 1'b1; ls_wdata = 32'h44332211; ls_req = 1'b1;
    step();
    checks++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h320) begin failures++; $display("FAIL arst_first got=%b/%h exp=1/320", mem_wr, mem_a); end
    step();
    #2;
    rst_n = 1'b0; ls_req = 1'b0;
    #1;
    checks++;
    if (mem_wr !== 1'b0 || mem_a !== 32'h0 || mem_dout !== 8'h0) begin
      failures++; $display("FAIL arst_bus got=%b/%h/%h exp=0/0/0", mem_wr, mem_a, mem_dout);
    end
    checks++;
    if (ls_ack !== 1'b0 || ls_rdata !== 32'h0 || if_ack !== 1'b0 || if_line !== '0) begin
      failures++; $display("FAIL arst_outs got=%b/%h/%b exp=0/0/0", ls_ack, ls_rdata, if_ack);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (ls_ack || mem_wr) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL arst_quiet got=%0d exp=0", bad); end
    checks++;
    if (rd(32'h320) !== 8'h11 || rd(32'h321) !== 8'h21) begin
      failures++; $display("FAIL arst_ram got=%h/%h exp=11/21", rd(32'h320), rd(32'h321));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ifetch();
    test_load("ld1s", 32'h200, 3'd1, 1'b1, 32'hFFFFFF80, 3);
    test_load("ld1u", 32'h200, 3'd1, 1'b0, 32'h00000080, 3);
    test_load("ld2s", 32'h210, 3'd2, 1'b1, 32'hFFFF9234, 4);
    test_load("ld3w", 32'h220, 3'd3, 1'b1, 32'h23222120, 6);
    test_io_store();
    test_store_rollback();
    test_read_rollback();
    test_rdy_load();
    test_rdy_store();
    test_arbitration();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
